// File: rtl/osd_dii_pkt_arbiter.sv
// rtl/osd_dii_pkt_arbiter.sv - packet-level arbiter sharing one debug-interconnect flit output
// Flits are 18 bits {valid, last, data[15:0]}; port i sits at in_flit[i*18 +: 18].
module osd_dii_pkt_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int IDXW      = $clog2(NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prio_mode,
  input  logic [NUM_PORTS*18-1:0] in_flit,
  output logic [NUM_PORTS-1:0]    in_ready,
  output logic [17:0]             out_flit,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [IDXW-1:0]         grant_idx
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]           state;
  logic [IDXW-1:0]      last_grant;
  logic [IDXW-1:0]      winner;
  logic [IDXW-1:0]      sel;
  logic [NUM_PORTS-1:0] req;
  logic                 any_req;
  logic                 accept;
  logic                 xfer;
  logic [17:0]          sel_flit;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++) req[i] = in_flit[i*18 + 17];
  end

  always_comb begin
    winner = '0;
    if (prio_mode) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--)
        if (req[i]) winner = IDXW'(i);
    end else begin
      // Walk farthest-to-nearest so the first requester after last_grant is the final write
      for (int k = NUM_PORTS; k >= 1; k--)
        if (req[(int'(last_grant) + k) % NUM_PORTS])
          winner = IDXW'((int'(last_grant) + k) % NUM_PORTS);
    end
  end

  assign any_req  = |req;
  assign accept   = !out_flit[17] || out_ready;
  assign busy     = (state == ST_LOCKED);
  assign sel      = busy ? grant_idx : winner;
  assign sel_flit = in_flit[int'(sel)*18 +: 18];

  always_comb begin
    in_ready = '0;
    if (!rst) begin
      if (busy)         in_ready[grant_idx] = accept;
      else if (any_req) in_ready[winner]    = accept;
    end
  end

  assign xfer = |(in_ready & req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_flit   <= '0;
      grant_idx  <= '0;
      last_grant <= IDXW'(NUM_PORTS - 1);
    end else begin
      if (accept) begin
        if (xfer) out_flit     <= sel_flit;
        else      out_flit[17] <= 1'b0;
      end
      if (xfer) begin
        // Fairness pointer moves only when a new packet is granted
        if (state == ST_IDLE) begin
          grant_idx  <= winner;
          last_grant <= winner;
        end
        state <= sel_flit[16] ? ST_IDLE : ST_LOCKED;
      end
    end
  end

endmodule

// File: tb/tb_osd_dii_pkt_arbiter.sv
// tb/tb_osd_dii_pkt_arbiter.sv - self-checking bench for osd_dii_pkt_arbiter
// Queue-fed sources, a per-cycle reference model and literal packet-order checks.
module tb_osd_dii_pkt_arbiter;
  localparam int NP = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            prio_mode = 1'b0;
  logic            out_ready = 1'b1;
  logic [NP*18-1:0] in_flit = '0;
  logic [NP-1:0]   in_ready;
  logic [17:0]     out_flit;
  logic            busy;
  logic [IW-1:0]   grant_idx;

  osd_dii_pkt_arbiter #(.NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .prio_mode(prio_mode), .in_flit(in_flit),
    .in_ready(in_ready), .out_flit(out_flit), .out_ready(out_ready),
    .busy(busy), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [17:0] src_q [NP][$];
  logic [15:0] log_q[$];
  int          log_cyc[$];
  logic [15:0] exp_q[$];

  // Reference model state
  int          m_owner = -1;
  int          m_last  = NP - 1;
  int          m_gidx  = 0;
  logic [17:0] m_out   = '0;
  int          m_grant = -1;
  logic        m_accept = 1'b0;
  logic [NP-1:0] m_rdy, smp_rdy;
  logic [NP*18-1:0] smp_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] mk(input logic v, input logic l, input logic [15:0] d);
    return {v, l, d};
  endfunction

  // Compare process: model decision for this cycle vs DUT outputs
  always @(negedge clk) begin
    if (!rst) begin
      smp_in  = in_flit;
      smp_rdy = in_ready;
      m_accept = !m_out[17] || out_ready;
      m_grant  = -1;
      if (m_owner >= 0) m_grant = m_owner;
      else begin
        for (int j = 0; j < NP; j++) begin
          int p;
          p = prio_mode ? j : (m_last + 1 + j) % NP;
          if (m_grant < 0 && in_flit[p*18 + 17]) m_grant = p;
        end
      end
      m_rdy = '0;
      if (m_grant >= 0 && m_accept) m_rdy[m_grant] = 1'b1;
      check("in_ready", in_ready, m_rdy);
      check("out_valid", out_flit[17], m_out[17]);
      if (m_out[17]) check("out_flit", out_flit, m_out);
      check("busy", busy, m_owner >= 0);
      check("grant_idx", grant_idx, m_gidx);
      if (out_flit[17] && out_ready) begin
        log_q.push_back(out_flit[15:0]);
        log_cyc.push_back(cyc);
      end
    end
  end

  // Model update, source pops and input drive
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_last = NP - 1; m_gidx = 0; m_out = '0;
    end else begin
      cyc++;
      if (m_accept) begin
        if (m_grant >= 0 && smp_in[m_grant*18 + 17]) begin
          m_out = smp_in[m_grant*18 +: 18];
          if (m_owner < 0) begin m_gidx = m_grant; m_last = m_grant; end
          m_owner = m_out[16] ? -1 : m_grant;
        end else m_out[17] = 1'b0;
      end
      for (int p = 0; p < NP; p++)
        if (src_q[p].size() > 0 && in_flit[p*18 +: 18] === src_q[p][0] &&
            (!src_q[p][0][17] || smp_rdy[p]))
          void'(src_q[p].pop_front());
    end
    #1;
    for (int p = 0; p < NP; p++)
      in_flit[p*18 +: 18] = (src_q[p].size() > 0) ? src_q[p][0] : 18'h0;
  end

  task automatic load_pkt(input int p, input logic [15:0] base, input int n);
    for (int k = 1; k <= n; k++) src_q[p].push_back(mk(1'b1, k == n, base + 16'(k)));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    do begin @(posedge clk); #2; n++; end
    while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size() != 0 ||
            out_flit[17]) && n < 300);
    check({name, " drain_timeout"}, n < 300, 1'b1);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!busy && n < 50) begin @(posedge clk); #2; n++; end
    check({name, " busy_timeout"}, busy, 1'b1);
  endtask

  task automatic check_log(input string name, input bit consec);
    check({name, " count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({name, " data"}, log_q[i], exp_q[i]);
      if (consec && i > 0) check({name, " gap"}, log_cyc[i] - log_cyc[i-1], 1);
    end
    log_q.delete(); log_cyc.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    log_q.delete(); log_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst in_ready", in_ready, 4'h0);
    check("rst out_valid", out_flit[17], 1'b0);
    check("rst out_flit", out_flit, 18'h0);
    check("rst busy", busy, 1'b0);
    check("rst grant_idx", grant_idx, 2'd0);
    @(posedge clk); #2 rst = 1'b0;

    // 1: two 3-flit packets, round robin
    @(posedge clk); #2;
    load_pkt(0, 16'h00A0, 3);
    load_pkt(1, 16'h00B0, 3);
    drain("t1");
    for (int k = 1; k <= 3; k++) exp_q.push_back(16'h00A0 + 16'(k));
    for (int k = 1; k <= 3; k++) exp_q.push_back(16'h00B0 + 16'(k));
    check_log("t1", 1'b1);
    check("t1 grant_idx", grant_idx, 2'd1);

    // 2: port 1 packet with valid gaps locks out port 0
    @(posedge clk); #2;
    src_q[1].push_back(mk(1'b1, 1'b0, 16'h00C1));
    src_q[1].push_back(mk(1'b0, 1'b0, 16'h0000));
    src_q[1].push_back(mk(1'b0, 1'b0, 16'h0000));
    src_q[1].push_back(mk(1'b1, 1'b0, 16'h00C2));
    src_q[1].push_back(mk(1'b0, 1'b0, 16'h0000));
    src_q[1].push_back(mk(1'b1, 1'b1, 16'h00C3));
    wait_busy("t2");
    load_pkt(0, 16'h00D0, 2);
    drain("t2");
    for (int k = 1; k <= 3; k++) exp_q.push_back(16'h00C0 + 16'(k));
    for (int k = 1; k <= 2; k++) exp_q.push_back(16'h00D0 + 16'(k));
    check_log("t2", 1'b0);

    // 3: single-flit packets on all ports, round robin then fixed priority
    do_reset();
    @(posedge clk); #2;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++) src_q[p].push_back(mk(1'b1, 1'b1, 16'h3000 + 16'(p*16 + k)));
    drain("t3rr");
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++) exp_q.push_back(16'h3000 + 16'(p*16 + k));
    check_log("t3rr", 1'b1);
    @(posedge clk); #2 prio_mode = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < NP; p++) src_q[p].push_back(mk(1'b1, 1'b1, 16'h3100 + 16'(p*16 + k)));
    drain("t3fp");
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 3; k++) exp_q.push_back(16'h3100 + 16'(p*16 + k));
    check_log("t3fp", 1'b1);

    // 4: downstream back-pressure holds the output register
    @(posedge clk); #2 prio_mode = 1'b0;
    out_ready = 1'b0;
    load_pkt(2, 16'hE000, 4);
    begin
      int n;
      n = 0;
      while (!out_flit[17] && n < 20) begin @(posedge clk); #2; n++; end
    end
    for (int i = 0; i < 5; i++) begin
      check("t4 hold data", out_flit, mk(1'b1, 1'b0, 16'hE001));
      check("t4 hold ready", in_ready, 4'h0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    drain("t4");
    for (int k = 1; k <= 4; k++) exp_q.push_back(16'hE000 + 16'(k));
    check_log("t4", 1'b1);

    // 5: asynchronous reset in the middle of a packet
    @(posedge clk); #2;
    load_pkt(0, 16'hF000, 4);
    wait_busy("t5");
    #1;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    rst = 1'b1;
    #1;
    check("t5 rst out_valid", out_flit[17], 1'b0);
    check("t5 rst busy", busy, 1'b0);
    check("t5 rst in_ready", in_ready, 4'h0);
    check("t5 rst grant_idx", grant_idx, 2'd0);
    @(posedge clk); #2 rst = 1'b0;
    log_q.delete(); log_cyc.delete();
    load_pkt(1, 16'h6000, 2);
    load_pkt(0, 16'h7000, 2);
    drain("t5");
    for (int k = 1; k <= 2; k++) exp_q.push_back(16'h7000 + 16'(k));
    for (int k = 1; k <= 2; k++) exp_q.push_back(16'h6000 + 16'(k));
    check_log("t5", 1'b0);

    // 6: prio_mode flips during a locked packet from port 2
    @(posedge clk); #2;
    load_pkt(2, 16'h5000, 4);
    wait_busy("t6");
    prio_mode = 1'b1;
    load_pkt(0, 16'h8000, 1);
    load_pkt(1, 16'h9000, 2);
    load_pkt(3, 16'hA000, 1);
    drain("t6");
    for (int k = 1; k <= 4; k++) exp_q.push_back(16'h5000 + 16'(k));
    exp_q.push_back(16'h8001);
    exp_q.push_back(16'h9001);
    exp_q.push_back(16'h9002);
    exp_q.push_back(16'hA001);
    check_log("t6", 1'b0);
    check("t6 grant_idx", grant_idx, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
